// File: rtl/tri_line_pkg.sv
// Shared types and constants for the tristate-line responder.
package tri_line_pkg;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic LINE_IDLE       = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    TURN,
    TX_START,
    TX_DATA,
    TX_STOP
  } tri_state_t;

  function automatic logic is_tx_state(input tri_state_t s);
    return (s == TX_START) || (s == TX_DATA) || (s == TX_STOP);
  endfunction

endpackage

// File: rtl/tri_line_responder_if.sv
// User-side command/reply port of the tristate-line responder.
interface tri_line_responder_if;
  import tri_line_pkg::*;

  logic [FRAME_DATA_BITS-1:0] rx_data;
  logic                       rx_valid;
  logic                       frame_err;
  logic [FRAME_DATA_BITS-1:0] tx_data;
  logic                       tx_load;
  logic                       tx_ready;

  modport master (
    input  rx_data, rx_valid, frame_err, tx_ready,
    output tx_data, tx_load
  );

  modport slave (
    output rx_data, rx_valid, frame_err, tx_ready,
    input  tx_data, tx_load
  );

endinterface

// File: rtl/line_sync.sv
// Two-flop pad synchronizer with a falling-edge detector whose history
// flop can be forced idle.
module line_sync
  import tri_line_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  input  logic hist_force,
  output logic rx_bit,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic hist_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= LINE_IDLE;
      sync_p1 <= LINE_IDLE;
      hist_p2 <= LINE_IDLE;
    end else begin
      sync_p0 <= line_in;
      sync_p1 <= sync_p0;
      // Forcing history high hides the level our own reply left behind.
      hist_p2 <= hist_force ? LINE_IDLE : sync_p1;
    end
  end

  assign rx_bit = sync_p1;
  assign fall   = hist_p2 & ~sync_p1;

endmodule

// File: rtl/tri_line_responder.sv
// Responder end of a half-duplex single-wire line: receives a framed
// command, then turns the line around and sends an optional reply byte.
module tri_line_responder
  import tri_line_pkg::*;
#(
  parameter int BIT_CYCLES  = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 line_in,
  output logic                 line_out,
  output logic                 line_oe,
  output logic                 busy,
  tri_line_responder_if.slave  usr
);

  localparam int                   BIT_IDX_W = $clog2(FRAME_DATA_BITS);
  localparam logic [7:0]           BIT_LD    = 8'(BIT_CYCLES);
  localparam logic [7:0]           HALF_LD   = 8'(BIT_CYCLES / 2);
  localparam logic [7:0]           TURN_LD   = 8'(TURN_CYCLES);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(FRAME_DATA_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_ONE   = BIT_IDX_W'(1);

  tri_state_t                 state, state_nxt;
  logic [7:0]                 cnt, cnt_nxt;
  logic [BIT_IDX_W-1:0]       bit_idx, bit_idx_nxt;
  logic [FRAME_DATA_BITS-1:0] rx_sh, rx_sh_nxt;
  logic [FRAME_DATA_BITS-1:0] tx_sh, tx_sh_nxt;
  logic [FRAME_DATA_BITS-1:0] tx_buf;
  logic [FRAME_DATA_BITS-1:0] rx_data_q;
  logic                       rx_valid_q, frame_err_q;
  logic                       tx_full, load_ok;
  logic                       rx_bit, fall, tick, hist_force;
  logic                       rx_take, err_take, tx_done;
  logic                       line_out_nxt, line_oe_nxt;

  line_sync u_line_sync (
    .clk        (clk),
    .rst        (rst),
    .line_in    (line_in),
    .hist_force (hist_force),
    .rx_bit     (rx_bit),
    .fall       (fall)
  );

  // The counter is reloaded with a period and the event fires when it
  // reaches 1, so an event lands exactly "period" clocks after the load.
  assign tick    = (cnt == 8'd1);
  assign load_ok = usr.tx_load & ~tx_full;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt - 8'd1;
    bit_idx_nxt = bit_idx;
    rx_sh_nxt   = rx_sh;
    tx_sh_nxt   = tx_sh;
    rx_take     = 1'b0;
    err_take    = 1'b0;
    tx_done     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = cnt;
        if (fall) begin
          state_nxt = RX_START;
          cnt_nxt   = HALF_LD;
        end
      end
      RX_START: if (tick) begin
        if (rx_bit) begin
          state_nxt = IDLE;
        end else begin
          state_nxt   = RX_DATA;
          cnt_nxt     = BIT_LD;
          bit_idx_nxt = '0;
        end
      end
      RX_DATA: if (tick) begin
        rx_sh_nxt   = {rx_bit, rx_sh[FRAME_DATA_BITS-1:1]};
        cnt_nxt     = BIT_LD;
        bit_idx_nxt = bit_idx + BIT_ONE;
        if (bit_idx == LAST_BIT) state_nxt = RX_STOP;
      end
      RX_STOP: if (tick) begin
        if (rx_bit) begin
          rx_take   = 1'b1;
          state_nxt = TURN;
          cnt_nxt   = TURN_LD;
        end else begin
          err_take  = 1'b1;
          state_nxt = IDLE;
        end
      end
      // The buffer flag is sampled before this edge, so a load arriving
      // on the expiry clock itself waits for the next command.
      TURN: if (tick) begin
        if (tx_full) begin
          state_nxt = TX_START;
          cnt_nxt   = BIT_LD;
          tx_sh_nxt = tx_buf;
        end else begin
          state_nxt = IDLE;
        end
      end
      TX_START: if (tick) begin
        state_nxt   = TX_DATA;
        cnt_nxt     = BIT_LD;
        bit_idx_nxt = '0;
      end
      TX_DATA: if (tick) begin
        cnt_nxt     = BIT_LD;
        bit_idx_nxt = bit_idx + BIT_ONE;
        if (bit_idx == LAST_BIT) state_nxt = TX_STOP;
        else                     tx_sh_nxt = tx_sh >> 1;
      end
      TX_STOP: if (tick) begin
        tx_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    line_oe_nxt = is_tx_state(state_nxt);
    case (state_nxt)
      TX_START: line_out_nxt = 1'b0;
      TX_DATA:  line_out_nxt = tx_sh_nxt[0];
      default:  line_out_nxt = LINE_IDLE;
    endcase
    hist_force = tx_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      bit_idx     <= '0;
      line_out    <= LINE_IDLE;
      line_oe     <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_data_q   <= '0;
      tx_full     <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      line_out    <= line_out_nxt;
      line_oe     <= line_oe_nxt;
      rx_valid_q  <= rx_take;
      frame_err_q <= err_take;
      if (rx_take) rx_data_q <= rx_sh;
      if (tx_done)      tx_full <= 1'b0;
      else if (load_ok) tx_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    rx_sh <= rx_sh_nxt;
    tx_sh <= tx_sh_nxt;
    if (load_ok) tx_buf <= usr.tx_data;
  end

  assign usr.rx_data   = rx_data_q;
  assign usr.rx_valid  = rx_valid_q;
  assign usr.frame_err = frame_err_q;
  assign usr.tx_ready  = ~tx_full;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_tri_line_responder.sv
// Scoreboard bench for tri_line_responder with BIT_CYCLES=4, TURN_CYCLES=2.
module tb_tri_line_responder;

  localparam int BIT_CYCLES  = 4;
  localparam int TURN_CYCLES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_level = 1'b1;
  logic line_in, line_out, line_oe, busy;

  tri_line_responder_if usr();

  assign line_in = line_oe ? line_out : init_level;

  tri_line_responder #(.BIT_CYCLES(BIT_CYCLES), .TURN_CYCLES(TURN_CYCLES)) dut (
    .clk(clk), .rst(rst), .line_in(line_in), .line_out(line_out),
    .line_oe(line_oe), .busy(busy), .usr(usr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Monitor state: written only by the monitor process.
  int   cyc = 0;
  int   rxv_cnt = 0, ferr_cnt = 0, oe_cycles = 0, oe_len = 0, oe_last_len = 0;
  int   oe_rise_cyc = 0, rxv_cyc = 0, n_bits = 0, rule_viol = 0;
  logic oe_prev = 1'b0, ready_at_fall = 1'b0;
  logic [7:0] obs_rx [0:63];
  logic       obs_bits [0:1023];

  // Scoreboard state: owned by the stimulus process.
  logic [7:0] exp_rx[$];
  logic       exp_bits[$];
  int         rd_rx = 0, rd_bit = 0;
  logic [7:0] last_rx = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (usr.rx_valid === 1'b1) begin
      if (rxv_cnt < 64) obs_rx[rxv_cnt] = usr.rx_data;
      rxv_cnt++;
      rxv_cyc = cyc;
    end
    if (usr.frame_err === 1'b1) ferr_cnt++;
    if (line_oe === 1'b1) begin
      if (!oe_prev) begin oe_rise_cyc = cyc; oe_len = 0; end
      if ((oe_len % BIT_CYCLES) == BIT_CYCLES/2 && n_bits < 1024) begin
        obs_bits[n_bits] = line_out;
        n_bits++;
      end
      oe_len++;
      oe_cycles++;
    end else begin
      if (oe_prev) begin oe_last_len = oe_len; ready_at_fall = usr.tx_ready; end
      if (!rst && line_out !== 1'b1) rule_viol++;
    end
    oe_prev = (line_oe === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic load_byte(input logic [7:0] d);
    @(negedge clk) usr.tx_data = d; usr.tx_load = 1'b1;
    @(negedge clk) usr.tx_load = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk) init_level = 1'b0;
    repeat (BIT_CYCLES-1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) init_level = b[i];
      repeat (BIT_CYCLES-1) @(negedge clk);
    end
    @(negedge clk) init_level = stop_bit;
    repeat (BIT_CYCLES-1) @(negedge clk);
    @(negedge clk) init_level = 1'b1;
  endtask

  task automatic push_reply(input logic [7:0] b);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    exp_bits.push_back(1'b1);
  endtask

  task automatic pop_rx(output logic [7:0] got, output logic [7:0] exp);
    exp = exp_rx.pop_front();
    got = (rd_rx < rxv_cnt) ? obs_rx[rd_rx] : 8'hxx;
    rd_rx = rxv_cnt;
    last_rx = exp;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin @(negedge clk); n++; end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    usr.tx_load = 1'b0;
    usr.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    n_vec++; if (line_out !== 1'b1)      begin n_err++; $display("FAIL rst_line_out: got %b required 1", line_out); end
    n_vec++; if (line_oe !== 1'b0)       begin n_err++; $display("FAIL rst_line_oe: got %b required 0", line_oe); end
    n_vec++; if (usr.rx_data !== 8'h00)  begin n_err++; $display("FAIL rst_rx_data: got %h required 00", usr.rx_data); end
    n_vec++; if (usr.rx_valid !== 1'b0)  begin n_err++; $display("FAIL rst_rx_valid: got %b required 0", usr.rx_valid); end
    n_vec++; if (usr.frame_err !== 1'b0) begin n_err++; $display("FAIL rst_frame_err: got %b required 0", usr.frame_err); end
    n_vec++; if (usr.tx_ready !== 1'b1)  begin n_err++; $display("FAIL rst_tx_ready: got %b required 1", usr.tx_ready); end
    n_vec++; if (busy !== 1'b0)          begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_cmd_no_reply();
    logic [7:0] got, exp;
    int r0 = rxv_cnt, o0 = oe_cycles;
    exp_rx.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_idle(60, "no_reply");
    n_vec++; if (rxv_cnt - r0 !== 1) begin n_err++; $display("FAIL no_reply_pulses: got %0d required 1", rxv_cnt - r0); end
    pop_rx(got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL no_reply_rx: got %h required %h", got, exp); end
    n_vec++; if (usr.rx_data !== exp) begin n_err++; $display("FAIL no_reply_hold: got %h required %h", usr.rx_data, exp); end
    n_vec++; if (oe_cycles - o0 !== 0) begin n_err++; $display("FAIL no_reply_oe: got %0d driven cycles required 0", oe_cycles - o0); end
  endtask

  task automatic test_cmd_with_reply();
    logic [7:0] got, exp;
    load_byte(8'h3C);
    n_vec++; if (usr.tx_ready !== 1'b0) begin n_err++; $display("FAIL reply_ready_after_load: got %b required 0", usr.tx_ready); end
    push_reply(8'h3C);
    rd_bit = n_bits;
    exp_rx.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    wait_idle(120, "reply");
    pop_rx(got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL reply_rx: got %h required %h", got, exp); end
    n_vec++; if (oe_rise_cyc - rxv_cyc !== TURN_CYCLES) begin n_err++; $display("FAIL reply_turn: got %0d clocks required %0d", oe_rise_cyc - rxv_cyc, TURN_CYCLES); end
    n_vec++; if (oe_last_len !== 10*BIT_CYCLES) begin n_err++; $display("FAIL reply_len: got %0d required %0d", oe_last_len, 10*BIT_CYCLES); end
    for (int i = 0; i < 10; i++) begin
      logic e, g;
      e = exp_bits.pop_front();
      g = (rd_bit < n_bits) ? obs_bits[rd_bit] : 1'bx;
      rd_bit++;
      n_vec++; if (g !== e) begin n_err++; $display("FAIL reply_bit%0d: got %b required %b", i, g, e); end
    end
    n_vec++; if (ready_at_fall !== 1'b1) begin n_err++; $display("FAIL reply_ready_at_fall: got %b required 1", ready_at_fall); end
    n_vec++; if (usr.tx_ready !== 1'b1) begin n_err++; $display("FAIL reply_ready_end: got %b required 1", usr.tx_ready); end
  endtask

  task automatic test_glitch();
    int r0 = rxv_cnt, f0 = ferr_cnt;
    logic seen = 1'b0;
    @(negedge clk) init_level = 1'b0;
    @(negedge clk) init_level = 1'b1;
    repeat (6) begin @(negedge clk); if (busy) seen = 1'b1; end
    n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL glitch_detect: busy seen %b required 1", seen); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b required 0", busy); end
    repeat (4) @(negedge clk);
    n_vec++; if (rxv_cnt - r0 !== 0 || ferr_cnt - f0 !== 0) begin
      n_err++; $display("FAIL glitch_pulses: rx_valid %0d frame_err %0d required 0 0", rxv_cnt - r0, ferr_cnt - f0);
    end
  endtask

  task automatic test_bad_stop();
    int r0, f0, o0;
    load_byte(8'h3C);
    r0 = rxv_cnt; f0 = ferr_cnt; o0 = oe_cycles;
    send_frame(8'hFF, 1'b0);
    wait_idle(60, "bad_stop");
    repeat (10) @(negedge clk);
    n_vec++; if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL bad_stop_err: got %0d pulses required 1", ferr_cnt - f0); end
    n_vec++; if (rxv_cnt - r0 !== 0) begin n_err++; $display("FAIL bad_stop_valid: got %0d pulses required 0", rxv_cnt - r0); end
    n_vec++; if (usr.rx_data !== last_rx) begin n_err++; $display("FAIL bad_stop_hold: got %h required %h", usr.rx_data, last_rx); end
    n_vec++; if (oe_cycles - o0 !== 0) begin n_err++; $display("FAIL bad_stop_oe: got %0d driven cycles required 0", oe_cycles - o0); end
    n_vec++; if (usr.tx_ready !== 1'b0) begin n_err++; $display("FAIL bad_stop_ready: got %b required 0", usr.tx_ready); end
  endtask

  task automatic test_second_load();
    logic [7:0] got, exp;
    load_byte(8'h99);
    n_vec++; if (usr.tx_ready !== 1'b0) begin n_err++; $display("FAIL second_load_ready: got %b required 0", usr.tx_ready); end
    push_reply(8'h3C);
    rd_bit = n_bits;
    exp_rx.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    wait_idle(120, "second_load");
    pop_rx(got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL second_load_rx: got %h required %h", got, exp); end
    n_vec++; if (oe_last_len !== 10*BIT_CYCLES) begin n_err++; $display("FAIL second_load_len: got %0d required %0d", oe_last_len, 10*BIT_CYCLES); end
    for (int i = 0; i < 10; i++) begin
      logic e, g;
      e = exp_bits.pop_front();
      g = (rd_bit < n_bits) ? obs_bits[rd_bit] : 1'bx;
      rd_bit++;
      n_vec++; if (g !== e) begin n_err++; $display("FAIL second_load_bit%0d: got %b required %b", i, g, e); end
    end
  endtask

  task automatic test_same_cycle_load();
    logic [7:0] got, exp;
    int o0 = oe_cycles;
    exp_rx.push_back(8'h24);
    fork
      send_frame(8'h24, 1'b1);
      begin
        int n = 0;
        do begin @(negedge clk); n++; end while (usr.rx_valid !== 1'b1 && n < 80);
        n_vec++; if (usr.rx_valid !== 1'b1) begin n_err++; $display("FAIL same_cycle_wait: rx_valid %b after %0d cycles required 1", usr.rx_valid, n); end
        @(negedge clk) usr.tx_data = 8'h66; usr.tx_load = 1'b1;
        @(negedge clk) usr.tx_load = 1'b0;
      end
    join
    wait_idle(60, "same_cycle");
    repeat (6) @(negedge clk);
    pop_rx(got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL same_cycle_rx: got %h required %h", got, exp); end
    n_vec++; if (oe_cycles - o0 !== 0) begin n_err++; $display("FAIL same_cycle_oe: got %0d driven cycles required 0", oe_cycles - o0); end
    n_vec++; if (usr.tx_ready !== 1'b0) begin n_err++; $display("FAIL same_cycle_ready: got %b required 0", usr.tx_ready); end
    // The late load is held and answers the following command.
    push_reply(8'h66);
    rd_bit = n_bits;
    exp_rx.push_back(8'h18);
    send_frame(8'h18, 1'b1);
    wait_idle(120, "late_reply");
    pop_rx(got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL late_reply_rx: got %h required %h", got, exp); end
    for (int i = 0; i < 10; i++) begin
      logic e, g;
      e = exp_bits.pop_front();
      g = (rd_bit < n_bits) ? obs_bits[rd_bit] : 1'bx;
      rd_bit++;
      n_vec++; if (g !== e) begin n_err++; $display("FAIL late_reply_bit%0d: got %b required %b", i, g, e); end
    end
  endtask

  task automatic test_reset_during_reply();
    logic [7:0] got, exp;
    int n = 0;
    load_byte(8'h81);
    exp_rx.push_back(8'h77);
    send_frame(8'h77, 1'b1);
    while (line_oe !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_vec++; if (line_oe !== 1'b1) begin n_err++; $display("FAIL rst_reply_start: line_oe %b after %0d cycles required 1", line_oe, n); end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (line_oe !== 1'b0)      begin n_err++; $display("FAIL mid_rst_oe: got %b required 0", line_oe); end
    n_vec++; if (line_out !== 1'b1)     begin n_err++; $display("FAIL mid_rst_out: got %b required 1", line_out); end
    n_vec++; if (usr.tx_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b required 1", usr.tx_ready); end
    n_vec++; if (busy !== 1'b0)         begin n_err++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
    pop_rx(got, exp);
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL mid_rst_rx: got %h required %h", got, exp); end
    rd_bit = n_bits;
    last_rx = 8'h00;
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, exp;
    int o0 = oe_cycles;
    for (int k = 0; k < 2; k++) begin
      logic [7:0] b;
      b = 8'(($urandom_range(0, 255)));
      exp_rx.push_back(b);
      send_frame(b, 1'b1);
      wait_idle(60, "b2b");
      pop_rx(got, exp);
      n_vec++; if (got !== exp) begin n_err++; $display("FAIL b2b_rx%0d: got %h required %h", k, got, exp); end
    end
    n_vec++; if (oe_cycles - o0 !== 0) begin n_err++; $display("FAIL b2b_oe: got %0d driven cycles required 0", oe_cycles - o0); end
    n_vec++; if (rule_viol !== 0) begin n_err++; $display("FAIL out_rule: line_out low while released %0d times, required 0", rule_viol); end
  endtask

  initial begin
    test_reset();
    test_cmd_no_reply();
    test_cmd_with_reply();
    test_glitch();
    test_bad_stop();
    test_second_load();
    test_same_cycle_load();
    test_reset_during_reply();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
